// File: rtl/qk_stream_issuer_if.sv
// Beat stream from the Q/K issuer toward the dot-product unit.
// The master drives the payload and valid; the slave returns ready.
interface qk_stream_issuer_if #(
    parameter int VW = 512,
    parameter int AW = 4
);
    logic          vld_out;
    logic          rdy_in;
    logic [VW-1:0] q_out;
    logic [VW-1:0] k_out;
    logic [AW-1:0] idx_out;
    logic          last_out;

    modport master (
        output vld_out, q_out, k_out, idx_out, last_out,
        input  rdy_in
    );

    modport slave (
        input  vld_out, q_out, k_out, idx_out, last_out,
        output rdy_in
    );
endinterface

// File: rtl/qk_stream_issuer.sv
// Q/K stream issuer: latches one Q vector per job, then reads NUM_K rows
// from the K tile buffer (1-cycle read latency) and emits each row paired
// with the held Q through a 2-entry output FIFO. Reads are credit-limited
// so that buffered plus in-flight rows never exceed the FIFO depth.
module qk_stream_issuer #(
    parameter int  DK     = 64,
    parameter int  ELEM_W = 8,
    parameter int  BC     = 16,
    localparam int VW     = DK * ELEM_W,
    localparam int AW     = $clog2(BC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_vld_in,
    output logic               q_rdy_out,
    input  logic [VW-1:0]      q_in,
    input  logic [AW:0]        num_k_in,
    output logic               k_rd_en,
    output logic [AW-1:0]      k_rd_addr,
    input  logic [VW-1:0]      k_rd_data,
    output logic               done_out,
    qk_stream_issuer_if.master beat
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_STREAM = 2'd1;
    localparam logic [1:0]  S_DONE   = 2'd2;
    localparam logic [AW:0] ONE_K    = {{AW{1'b0}}, 1'b1};

    logic [1:0]    r_state;
    logic [VW-1:0] r_q;
    logic [AW:0]   r_numK;
    logic [AW:0]   r_rdPtr;
    logic          r_inflight;
    logic [AW-1:0] r_inflightAddr;
    logic [VW-1:0] r_fifoK    [2];
    logic [AW-1:0] r_fifoIdx  [2];
    logic          r_fifoLast [2];
    logic          r_head;
    logic [1:0]    r_count;

    logic          w_accept;
    logic          w_pop;
    logic [2:0]    w_credit;
    logic          w_rdEn;
    logic          w_wrSel;
    logic          w_pushLast;
    logic          w_lastBeat;

    // Handshake decode, read credit and FIFO write slot for this cycle.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && q_vld_in;
        w_pop      = (r_count != 2'd0) && beat.rdy_in;
        w_credit   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_rdEn     = (r_state == S_STREAM) && (r_rdPtr < r_numK) && (w_credit < 3'd2);
        w_wrSel    = r_head ^ r_count[0];
        w_pushLast = ({1'b0, r_inflightAddr} == (r_numK - ONE_K));
        w_lastBeat = w_pop && r_fifoLast[r_head];
    end

    assign q_rdy_out     = (r_state == S_IDLE);
    assign done_out      = (r_state == S_DONE);
    assign k_rd_en       = w_rdEn;
    assign k_rd_addr     = w_rdEn ? r_rdPtr[AW-1:0] : '0;
    assign beat.vld_out  = (r_count != 2'd0);
    assign beat.q_out    = r_q;
    assign beat.k_out    = beat.vld_out ? r_fifoK[r_head] : '0;
    assign beat.idx_out  = beat.vld_out ? r_fifoIdx[r_head] : '0;
    assign beat.last_out = beat.vld_out && r_fifoLast[r_head];

    // Job sequencing, Q capture and K read pointer; the in-flight flag
    // remembers which row address will return next cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_q            <= '0;
            r_numK         <= '0;
            r_rdPtr        <= '0;
            r_inflight     <= 1'b0;
            r_inflightAddr <= '0;
        end else begin
            r_inflight     <= w_rdEn;
            r_inflightAddr <= r_rdPtr[AW-1:0];
            if (w_rdEn) begin
                r_rdPtr <= r_rdPtr + ONE_K;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_q     <= q_in;
                        r_numK  <= num_k_in;
                        r_rdPtr <= '0;
                        r_state <= (num_k_in == '0) ? S_DONE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_lastBeat) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry output FIFO: returned rows are pushed on arrival and the
    // head is popped on each transferred beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifoK[i]    <= '0;
                r_fifoIdx[i]  <= '0;
                r_fifoLast[i] <= 1'b0;
            end
        end else begin
            if (r_inflight) begin
                r_fifoK[w_wrSel]    <= k_rd_data;
                r_fifoIdx[w_wrSel]  <= r_inflightAddr;
                r_fifoLast[w_wrSel] <= w_pushLast;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_qk_stream_issuer.sv
// Bench for qk_stream_issuer: a job-level model (expected row sequence,
// read count, done cycle, held Q) is compared against the DUT every cycle,
// and directed jobs pin latency and boundary behaviour with literal values.
module tb_qk_stream_issuer;

    localparam int DK     = 64;
    localparam int ELEM_W = 8;
    localparam int BC     = 16;
    localparam int VW     = DK * ELEM_W;
    localparam int AW     = $clog2(BC);

    logic          clk = 1'b0;
    logic          rst;
    logic          q_vld_in;
    logic          q_rdy_out;
    logic [VW-1:0] q_in;
    logic [AW:0]   num_k_in;
    logic          k_rd_en;
    logic [AW-1:0] k_rd_addr;
    logic [VW-1:0] k_rd_data;
    logic          done_out;

    qk_stream_issuer_if #(.VW(VW), .AW(AW)) beat ();

    qk_stream_issuer #(.DK(DK), .ELEM_W(ELEM_W), .BC(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_vld_in  (q_vld_in),
        .q_rdy_out (q_rdy_out),
        .q_in      (q_in),
        .num_k_in  (num_k_in),
        .k_rd_en   (k_rd_en),
        .k_rd_addr (k_rd_addr),
        .k_rd_data (k_rd_data),
        .done_out  (done_out),
        .beat      (beat)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [VW-1:0] kBuf [BC];
    logic          memEn = 1'b0;
    logic [AW-1:0] memAddr = '0;

    bit            busy = 1'b0;
    int            n = 0;
    int            nextIdx = 0;
    int            reads = 0;
    int            doneCyc = -1;
    logic [VW-1:0] expQ = '0;
    bit            resetPending = 1'b0;
    bit            prevStall = 1'b0;

    task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Cycle counter, stable when sampled on the falling edge.
    always @(posedge clk) cyc++;

    // K tile buffer: capture the read request, return the row one cycle
    // later; junk is driven whenever no row is due.
    always @(negedge clk) begin
        memEn   = k_rd_en;
        memAddr = k_rd_addr;
    end
    always @(posedge clk) begin
        #1;
        k_rd_data = memEn ? kBuf[memAddr] : randVec();
    end

    // Illegal job sizes must never be requested.
    always @(posedge clk) begin
        if (rst === 1'b1 && q_vld_in === 1'b1)
            assert (num_k_in <= (AW+1)'(BC)) else $error("[TB] illegal num_k_in %0d", num_k_in);
    end

    // Job-level model compared against the DUT on every falling edge.
    always @(negedge clk) begin
        bit acceptNow;
        if (rst !== 1'b1) begin
            busy = 0; n = 0; nextIdx = 0; reads = 0; doneCyc = -1;
            expQ = '0; resetPending = 1; prevStall = 0;
        end else begin
            if (resetPending) begin
                checkOutput("rst vld_out", beat.vld_out, 0);
                checkOutput("rst k_rd_en", k_rd_en, 0);
                checkOutput("rst k_rd_addr", k_rd_addr, 0);
                checkOutput("rst last_out", beat.last_out, 0);
                checkOutput("rst done_out", done_out, 0);
                checkOutput("rst q_out", beat.q_out, 0);
                checkOutput("rst k_out", beat.k_out, 0);
                checkOutput("rst idx_out", beat.idx_out, 0);
                checkOutput("rst q_rdy_out", q_rdy_out, 1);
                resetPending = 0;
            end
            acceptNow = q_vld_in && !busy;
            checkOutput("q_rdy_out", q_rdy_out, !busy);
            checkOutput("done_out", done_out, (cyc == doneCyc));
            checkOutput("q_out", beat.q_out, expQ);
            if (beat.vld_out) begin
                checkOutput("beat legal", (busy && nextIdx < n), 1);
                if (busy && nextIdx < n) begin
                    checkOutput("k_out", beat.k_out, kBuf[nextIdx]);
                    checkOutput("idx_out", beat.idx_out, nextIdx);
                    checkOutput("last_out", beat.last_out, (nextIdx == n - 1));
                end
            end else begin
                checkOutput("vld held in stall", prevStall, 0);
            end
            prevStall = beat.vld_out && !beat.rdy_in;
            if (k_rd_en) begin
                checkOutput("read legal", (busy && reads < n), 1);
                checkOutput("k_rd_addr", k_rd_addr, reads);
                reads++;
            end
            if (beat.vld_out && beat.rdy_in && busy) begin
                nextIdx++;
                if (nextIdx == n) doneCyc = cyc + 1;
            end
            checkOutput("outstanding<=2", ((reads - nextIdx) > 2), 0);
            if (cyc == doneCyc) begin
                busy = 0;
                doneCyc = -1;
            end
            if (acceptNow) begin
                busy = 1; n = int'(num_k_in); nextIdx = 0; reads = 0;
                expQ = q_in;
                doneCyc = (n == 0) ? cyc + 1 : -1;
            end
        end
    end

    task automatic fillK();
        for (int i = 0; i < BC; i++) kBuf[i] = randVec();
    endtask

    // Present a job and hold it until accepted; returns the accept cycle.
    task automatic applyStimulus(input logic [VW-1:0] q, input int k, output int accAt);
        q_vld_in = 1'b1;
        q_in     = q;
        num_k_in = (AW+1)'(k);
        accAt    = -1;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (q_rdy_out) begin
                accAt = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        q_vld_in = 1'b0;
        if (accAt < 0) checkOutput("accept timeout", 0, 1);
    endtask

    // Drive ready (constant or stall pattern) until done; returns the
    // first valid-beat cycle and the done cycle.
    task automatic runJob(input int mode, output int fv, output int dn);
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        fv = -1;
        dn = -1;
        for (int i = 0; i < 300; i++) begin
            beat.rdy_in = (mode == 0) ? 1'b1 : pat[i % 6];
            @(negedge clk);
            if (beat.vld_out && fv < 0) fv = cyc;
            if (done_out) begin
                dn = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        if (dn < 0) checkOutput("done timeout", 0, 1);
    endtask

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed job sequence.
    initial begin
        int acc, acc2, fv, dn, cnt;
        logic [VW-1:0] qa, qb;
        rst = 1'b0; q_vld_in = 1'b0; q_in = '0; num_k_in = '0;
        beat.rdy_in = 1'b0; k_rd_data = '0;
        for (int i = 0; i < BC; i++) kBuf[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] job 1: num_k=4, ready held high");
        fillK();
        beat.rdy_in = 1'b1;
        applyStimulus(randVec(), 4, acc);
        runJob(0, fv, dn);
        checkOutput("t1 first beat latency", fv - acc, 3);
        checkOutput("t1 done latency", dn - acc, 7);
        checkOutput("t1 reads", reads, 4);

        $display("[TB] job 2: num_k=8, ready stall pattern");
        fillK();
        applyStimulus(randVec(), 8, acc);
        runJob(1, fv, dn);
        checkOutput("t2 first beat latency", fv - acc, 3);
        checkOutput("t2 beats", nextIdx, 8);

        $display("[TB] job 3: num_k=0");
        beat.rdy_in = 1'b1;
        applyStimulus(randVec(), 0, acc);
        runJob(0, fv, dn);
        checkOutput("t3 done latency", dn - acc, 1);
        checkOutput("t3 no beat", fv, -1);
        checkOutput("t3 no reads", reads, 0);
        @(negedge clk);
        checkOutput("t3 q_rdy_out at T+2", q_rdy_out, 1);
        @(posedge clk); #1;

        $display("[TB] job 4: num_k=16");
        fillK();
        applyStimulus(randVec(), BC, acc);
        runJob(0, fv, dn);
        checkOutput("t4 first beat latency", fv - acc, 3);
        checkOutput("t4 done latency", dn - acc, 19);
        checkOutput("t4 reads", reads, 16);

        $display("[TB] job 5: second request while busy");
        fillK();
        qa = randVec();
        qb = randVec();
        applyStimulus(qa, 3, acc);
        @(posedge clk); #1;
        applyStimulus(qb, 2, acc2);
        checkOutput("t5 second accept cycle", acc2 - acc, 7);
        @(negedge clk);
        checkOutput("t5 q_out second job", beat.q_out, qb);
        @(posedge clk); #1;
        runJob(0, fv, dn);

        $display("[TB] job 6: reset mid-job");
        fillK();
        applyStimulus(randVec(), 6, acc);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (beat.vld_out && beat.rdy_in) cnt++;
            @(posedge clk); #1;
        end
        checkOutput("t6 beats before reset", cnt, 2);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6 vld_out after reset", beat.vld_out, 0);
        checkOutput("t6 q_rdy_out after reset", q_rdy_out, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (beat.vld_out) cnt++;
        end
        checkOutput("t6 no stale beats", cnt, 0);
        @(posedge clk); #1;

        $display("[TB] job 7: recovery after reset");
        fillK();
        applyStimulus(randVec(), 2, acc);
        runJob(0, fv, dn);
        checkOutput("t7 done latency", dn - acc, 5);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
